// File: rtl/lcd1602_bus_receiver_if.sv
// ----------------------------------------------------------------------------
// lcd1602_bus_receiver_if
//   HD44780-style 8-bit parallel LCD bus, as driven by the display drivers.
//
//   Signals:
//     lcd_en  bus strobe; the transfer is latched on its falling edge
//     lcd_rs  1 = data (character), 0 = command
//     lcd_db  8-bit bus data
//
//   Handshake: there is no back-pressure. The master holds lcd_rs/lcd_db
//   stable while lcd_en is high and across its falling edge; every
//   falling edge of lcd_en is one transfer. The slave never stalls the bus.
//   A strobe that arrives while the slave is busy is dropped and flagged.
//
//   Modports:
//     master  drives the bus (display driver / testbench)
//     slave   samples the bus (lcd1602_bus_receiver)
// ----------------------------------------------------------------------------
interface lcd1602_bus_receiver_if;
    logic       lcd_en;
    logic       lcd_rs;
    logic [7:0] lcd_db;

    modport master (output lcd_en, output lcd_rs, output lcd_db);
    modport slave  (input  lcd_en, input  lcd_rs, input  lcd_db);
endinterface

// File: rtl/lcd1602_bus_receiver.sv
// ----------------------------------------------------------------------------
// lcd1602_bus_receiver
//   Responder end of an HD44780-style 8-bit LCD bus. Synchronizes the bus
//   pins, detects falling edges of lcd_en, decodes commands and writes
//   characters into a 2x16 shadow DDRAM that can be read back.
//
//   Ports:
//     clk         system clock
//     rst         asynchronous, active-low reset
//     bus         LCD bus (slave modport): lcd_en, lcd_rs, lcd_db
//     rd_addr     shadow read index {line, column[3:0]}
//     rd_data     character at rd_addr, registered (1-cycle latency)
//     cursor      current address counter {line, column}
//     display_on  display-control D bit
//     busy        clear sweep in progress
//     char_wr     one-cycle pulse per accepted character write
//     cmd_err     sticky: unsupported command or out-of-range DDRAM address
//     overrun     sticky: strobe arrived while busy
//     state_dbg   FSM state (0 = IDLE, 1 = CLEAR)
// ----------------------------------------------------------------------------
module lcd1602_bus_receiver #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_CHAR   = 8'h20
) (
    input  logic                        clk,
    input  logic                        rst,
    lcd1602_bus_receiver_if.slave       bus,
    input  logic [4:0]                  rd_addr,
    output logic [7:0]                  rd_data,
    output logic [4:0]                  cursor,
    output logic                        display_on,
    output logic                        busy,
    output logic                        char_wr,
    output logic                        cmd_err,
    output logic                        overrun,
    output logic                        state_dbg
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t state, state_next;

    // Synchronizers: all three bus fields go through the same depth so the
    // rs/db values seen at the synced edge are the ones present at the pin edge.
    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] rs_sync;
    logic [7:0]             db_sync [SYNC_STAGES];
    logic                   en_last;

    logic       en_s;
    logic       rs_s;
    logic [7:0] db_s;
    logic       strobe;

    assign en_s   = en_sync[SYNC_STAGES-1];
    assign rs_s   = rs_sync[SYNC_STAGES-1];
    assign db_s   = db_sync[SYNC_STAGES-1];
    assign strobe = en_last & ~en_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_sync <= '0;
            rs_sync <= '0;
            en_last <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                db_sync[i] <= '0;
            end
        end else begin
            en_sync    <= {en_sync[SYNC_STAGES-2:0], bus.lcd_en};
            rs_sync    <= {rs_sync[SYNC_STAGES-2:0], bus.lcd_rs};
            en_last    <= en_s;
            db_sync[0] <= bus.lcd_db;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                db_sync[i] <= db_sync[i-1];
            end
        end
    end

    // Shadow DDRAM and control state
    logic [7:0] shadow [32];
    logic [4:0] sweep_cnt;
    logic       incr;

    // Decoded actions for this cycle
    logic data_wr;
    logic ld_addr;
    logic home;
    logic set_id;
    logic set_disp;
    logic set_err;
    logic set_ovr;
    logic clear_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command decode follows the HD44780 rule: the highest set bit picks
    // the instruction, lower bits are its arguments.
    always_comb begin
        state_next = state;
        data_wr    = 1'b0;
        ld_addr    = 1'b0;
        home       = 1'b0;
        set_id     = 1'b0;
        set_disp   = 1'b0;
        set_err    = 1'b0;
        set_ovr    = 1'b0;
        clear_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (strobe) begin
                    if (rs_s) begin
                        data_wr = 1'b1;
                    end else begin
                        casez (db_s)
                            8'b1???????: begin
                                ld_addr = 1'b1;
                                set_err = (db_s[5:4] != 2'b00);
                            end
                            8'b01??????: set_err  = 1'b1;
                            8'b001?????: set_err  = ~db_s[4];
                            8'b0001????: set_err  = 1'b1;
                            8'b00001???: set_disp = 1'b1;
                            8'b000001??: set_id   = 1'b1;
                            8'b0000001?: home     = 1'b1;
                            8'b00000001: state_next = ST_CLEAR;
                            default: ;
                        endcase
                    end
                end
            end
            ST_CLEAR: begin
                set_ovr = strobe;
                if (sweep_cnt == 5'd31) begin
                    clear_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cursor     <= '0;
            incr       <= 1'b1;
            display_on <= 1'b0;
            char_wr    <= 1'b0;
            cmd_err    <= 1'b0;
            overrun    <= 1'b0;
            sweep_cnt  <= '0;
            rd_data    <= FILL_CHAR;
            for (int i = 0; i < 32; i++) begin
                shadow[i] <= FILL_CHAR;
            end
        end else begin
            char_wr <= data_wr;
            // Read before any same-cycle write lands: old value is returned.
            rd_data <= shadow[rd_addr];

            if (data_wr) begin
                shadow[cursor] <= db_s;
                // 5-bit {line, col} wraps naturally: 0x0F -> 0x10 -> ... -> 0x1F -> 0x00
                cursor <= incr ? cursor + 5'd1 : cursor - 5'd1;
            end
            if (ld_addr) begin
                cursor <= {db_s[6], db_s[3:0]};
            end
            if (home) begin
                cursor <= '0;
            end
            if (set_id) begin
                incr <= db_s[1];
            end
            if (set_disp) begin
                display_on <= db_s[2];
            end
            if (set_err) begin
                cmd_err <= 1'b1;
            end
            if (set_ovr) begin
                overrun <= 1'b1;
            end

            if (state == ST_CLEAR) begin
                shadow[sweep_cnt] <= FILL_CHAR;
                sweep_cnt         <= sweep_cnt + 5'd1;
            end else begin
                sweep_cnt <= '0;
            end
            if (clear_done) begin
                cursor <= '0;
                incr   <= 1'b1;
            end
        end
    end

    assign busy      = (state == ST_CLEAR);
    assign state_dbg = state;

endmodule

// File: tb/tb_lcd1602_bus_receiver.sv
// ----------------------------------------------------------------------------
// tb_lcd1602_bus_receiver
//   Self-checking bench for lcd1602_bus_receiver: a table of bus transfers
//   with expected cursor/display/error state, read-port checks through an
//   expected queue, and hand-written sequences for clear, overrun, reset
//   during the sweep and back-to-back transfers.
// ----------------------------------------------------------------------------
module tb_lcd1602_bus_receiver;

    localparam int SYNC_STAGES = 2;

    logic       clk;
    logic       rst;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [4:0] cursor;
    logic       display_on;
    logic       busy;
    logic       char_wr;
    logic       cmd_err;
    logic       overrun;
    logic       state_dbg;

    lcd1602_bus_receiver_if bus_if ();

    lcd1602_bus_receiver #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILL_CHAR   (8'h20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if.slave),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cursor     (cursor),
        .display_on (display_on),
        .busy       (busy),
        .char_wr    (char_wr),
        .cmd_err    (cmd_err),
        .overrun    (overrun),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_pass   = 0;
    int         wr_pulses = 0;
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        if (char_wr === 1'b1) wr_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    // One transfer takes two clocks: en high one cycle, low one cycle.
    task automatic bus_xfer(input logic rs, input logic [7:0] db);
        @(negedge clk);
        bus_if.lcd_rs = rs;
        bus_if.lcd_db = db;
        bus_if.lcd_en = 1'b1;
        @(negedge clk);
        bus_if.lcd_en = 1'b0;
    endtask

    task automatic settle();
        repeat (SYNC_STAGES + 3) @(negedge clk);
    endtask

    task automatic read_cell(input logic [4:0] a, input logic [7:0] exp);
        logic [7:0] e;
        @(negedge clk);
        rd_addr = a;
        exp_q.push_back(exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check($sformatf("rd_data[%0d]", a), {24'd0, rd_data}, {24'd0, e});
    endtask

    task automatic wait_busy();
        int t;
        t = 0;
        while (busy !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("busy_rise", {31'd0, busy}, 32'd1);
    endtask

    task automatic clear_and_count(output int busy_cycles);
        bus_xfer(1'b0, 8'h01);
        busy_cycles = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rs;
        logic [7:0] db;
        logic [4:0] exp_cursor;
        logic       exp_disp;
        logic       exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic apply_vec(input int i);
        bus_xfer(vecs[i].rs, vecs[i].db);
        settle();
        check($sformatf("vec%0d cursor", i), {27'd0, cursor}, {27'd0, vecs[i].exp_cursor});
        check($sformatf("vec%0d display_on", i), {31'd0, display_on}, {31'd0, vecs[i].exp_disp});
        check($sformatf("vec%0d cmd_err", i), {31'd0, cmd_err}, {31'd0, vecs[i].exp_err});
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int bc;
        int p0;

        vecs[0]  = '{1'b0, 8'h38, 5'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h0C, 5'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h06, 5'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h80, 5'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h4A, 5'h01, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h57, 5'h02, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h8F, 5'h0F, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h41, 5'h10, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'h42, 5'h11, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h04, 5'h11, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'h80, 5'h00, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'h5A, 5'h1F, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 8'h02, 5'h00, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 8'h06, 5'h00, 1'b1, 1'b0};

        rst           = 1'b0;
        rd_addr       = '0;
        bus_if.lcd_en = 1'b0;
        bus_if.lcd_rs = 1'b0;
        bus_if.lcd_db = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        check("reset cursor", {27'd0, cursor}, 32'd0);
        check("reset display_on", {31'd0, display_on}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset char_wr", {31'd0, char_wr}, 32'd0);
        check("reset cmd_err", {31'd0, cmd_err}, 32'd0);
        check("reset overrun", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 32; i++) read_cell(i[4:0], 8'h20);

        // Init commands, then clear
        for (int i = 0; i < 3; i++) apply_vec(i);
        clear_and_count(bc);
        check("clear busy cycles", bc, 32'd32);
        check("clear cursor", {27'd0, cursor}, 32'd0);
        check("clear cmd_err", {31'd0, cmd_err}, 32'd0);
        check("clear display_on", {31'd0, display_on}, 32'd1);

        // Writes, line wrap and decrement wrap
        p0 = wr_pulses;
        for (int i = 3; i < 14; i++) apply_vec(i);
        check("char_wr pulses", wr_pulses - p0, 32'd5);
        read_cell(5'd0,  8'h5A);
        read_cell(5'd1,  8'h57);
        read_cell(5'd15, 8'h41);
        read_cell(5'd16, 8'h42);
        read_cell(5'd2,  8'h20);

        // Out-of-range DDRAM address
        bus_xfer(1'b0, 8'hA0);
        settle();
        check("A0 cmd_err", {31'd0, cmd_err}, 32'd1);
        check("A0 cursor", {27'd0, cursor}, 32'd0);

        // Strobe during the clear sweep is dropped
        p0 = wr_pulses;
        bus_xfer(1'b0, 8'h01);
        wait_busy();
        repeat (5) @(negedge clk);
        bus_xfer(1'b1, 8'h33);
        repeat (40) @(negedge clk);
        check("sweep overrun", {31'd0, overrun}, 32'd1);
        check("sweep busy done", {31'd0, busy}, 32'd0);
        check("sweep no char_wr", wr_pulses - p0, 32'd0);
        check("sweep cursor", {27'd0, cursor}, 32'd0);
        read_cell(5'd0, 8'h20);

        // Place a character on line 1, then reset during a sweep
        bus_xfer(1'b0, 8'hC4);
        bus_xfer(1'b1, 8'h55);
        settle();
        check("C4 cursor", {27'd0, cursor}, 32'h15);
        read_cell(5'd20, 8'h55);
        bus_xfer(1'b0, 8'h01);
        wait_busy();
        repeat (6) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("in-reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst cursor", {27'd0, cursor}, 32'd0);
        check("rst display_on", {31'd0, display_on}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst state", {31'd0, state_dbg}, 32'd0);
        check("rst cmd_err", {31'd0, cmd_err}, 32'd0);
        check("rst overrun", {31'd0, overrun}, 32'd0);
        check("rst rd_data", {24'd0, rd_data}, 32'h20);
        read_cell(5'd20, 8'h20);
        repeat (40) @(negedge clk);
        check("rst no late sweep", {31'd0, busy}, 32'd0);

        // Back-to-back data transfers every two clocks
        p0 = wr_pulses;
        bus_xfer(1'b1, 8'h61);
        bus_xfer(1'b1, 8'h62);
        bus_xfer(1'b1, 8'h63);
        settle();
        check("b2b cursor", {27'd0, cursor}, 32'd3);
        check("b2b pulses", wr_pulses - p0, 32'd3);
        read_cell(5'd0, 8'h61);
        read_cell(5'd1, 8'h62);
        read_cell(5'd2, 8'h63);

        // Function set in 4-bit mode is flagged
        bus_xfer(1'b0, 8'h28);
        settle();
        check("28 cmd_err", {31'd0, cmd_err}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
